layer_2: RTL

LAYER_2 -- requirements
Module: layer_2

---
 rtl/l2_pkg.sv | 38 +++
 rtl/layer_2_if.sv | 27 ++
 rtl/l2_wrom.sv | 39 +++
 rtl/layer_2.sv | 123 ++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types, widths and result saturation for layer_2
//
// Holds the FSM state enum, datapath widths (DW sample, AW accumulator,
// KW elements per 3x3 window), the default bias, and the helper that
// turns an accumulator into a ReLU-clamped Q9.8 result.
package l2_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP  = 3'd1,
        MAC  = 3'd2,
        OUT  = 3'd3,
        WAIT = 3'd4
    } l2_state_t;

    localparam int DW = 18;
    localparam int AW = 41;
    localparam int KW = 9;

    localparam logic signed [DW-1:0] L2_BIAS = 18'sd128;

    // Largest positive DW-bit result, held at accumulator width for comparison.
    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);

    // Drop the fractional scaling, clamp negatives to zero and saturate at SAT_MAX.
    function automatic logic signed [DW-1:0] sat_relu(input logic signed [AW-1:0] acc,
                                                      input int frac);
        logic signed [AW-1:0] s;
        s = acc >>> frac;
        if (s < 0)
            return '0;
        else if (s > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else
            return s[DW-1:0];
    endfunction

endpackage

// File: rtl/layer_2_if.sv
// rtl/layer_2_if.sv - window-in / result-out handshake bundle for layer_2
//
// master: producer + downstream side (drives rdy, din_0, din_1, bsy_in)
// slave : layer_2 side (drives bsy_out, dout, vld, last)
interface layer_2_if;
    import l2_pkg::*;

    logic                 rdy;
    logic signed [DW-1:0] din_0;
    logic signed [DW-1:0] din_1;
    logic                 bsy_out;
    logic                 bsy_in;
    logic signed [DW-1:0] dout;
    logic                 vld;
    logic                 last;

    modport master (
        output rdy, din_0, din_1, bsy_in,
        input  bsy_out, dout, vld, last
    );

    modport slave (
        input  rdy, din_0, din_1, bsy_in,
        output bsy_out, dout, vld, last
    );

endinterface

// File: rtl/l2_wrom.sv
// rtl/l2_wrom.sv - combinational 3x3 weight table for both channels
//
// Ports: k (element index 0..8, row-major) -> w0, w1 (Q9.8 signed weights).
// TEST_W=1 forces every weight to 1.0 (1<<FRAC).
module l2_wrom
    import l2_pkg::*;
#(
    parameter int FRAC   = 8,
    parameter bit TEST_W = 1'b0
) (
    input  logic [3:0]           k,
    output logic signed [DW-1:0] w0,
    output logic signed [DW-1:0] w1
);

    always_comb begin
        w0 = '0;
        w1 = '0;
        if (TEST_W) begin
            w0 = DW'(1 << FRAC);
            w1 = DW'(1 << FRAC);
        end else begin
            // Channel 0: smoothing kernel; channel 1: horizontal gradient.
            case (k)
                4'd0: begin w0 = 18'sd32;  w1 = -18'sd32; end
                4'd1: begin w0 = 18'sd64;  w1 = 18'sd0;   end
                4'd2: begin w0 = 18'sd32;  w1 = 18'sd32;  end
                4'd3: begin w0 = 18'sd64;  w1 = -18'sd64; end
                4'd4: begin w0 = 18'sd128; w1 = 18'sd0;   end
                4'd5: begin w0 = 18'sd64;  w1 = 18'sd64;  end
                4'd6: begin w0 = 18'sd32;  w1 = -18'sd32; end
                4'd7: begin w0 = 18'sd64;  w1 = 18'sd0;   end
                4'd8: begin w0 = 18'sd32;  w1 = 18'sd32;  end
                default: begin w0 = '0; w1 = '0; end
            endcase
        end
    end

endmodule

// File: rtl/layer_2.sv
// rtl/layer_2.sv - two-channel 3x3 MAC filter with ReLU/saturation and window count
//
// Ports: clk, rst_n (async active-low), tx_done (sync frame clear),
//        bus (layer_2_if.slave): rdy, din_0, din_1 in; bsy_out out;
//        bsy_in in; dout, vld, last out.
// A window streams in over 9 cycles after launch, products are registered
// once and accumulated, and the clamped result is offered on dout/vld.
module layer_2
    import l2_pkg::*;
#(
    parameter int FRAC   = 8,
    parameter int N_WIN  = 121,
    parameter bit TEST_W = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tx_done,
    layer_2_if.slave  bus
);

    localparam int WCW = $clog2(N_WIN);
    localparam logic signed [DW-1:0] BIAS      = TEST_W ? '0 : L2_BIAS;
    localparam logic signed [AW-1:0] BIAS_INIT = AW'(BIAS) <<< FRAC;

    l2_state_t              state;
    logic [3:0]             k;
    logic                   mac_cnt;
    logic                   pv;
    logic signed [2*DW-1:0] p0;
    logic signed [2*DW-1:0] p1;
    logic signed [AW-1:0]   acc;
    logic [WCW-1:0]         win_cnt;
    logic                   bsy_q;
    logic signed [DW-1:0]   dout_q;
    logic signed [DW-1:0]   w0;
    logic signed [DW-1:0]   w1;
    logic                   fire;

    l2_wrom #(.FRAC(FRAC), .TEST_W(TEST_W)) u_wrom (
        .k  (k),
        .w0 (w0),
        .w1 (w1)
    );

    // The result is offered from OUT/WAIT in the same cycle downstream is free,
    // so a stall ending releases vld without an extra cycle of latency.
    assign fire        = ((state == OUT) || (state == WAIT)) && !bus.bsy_in && !tx_done;
    assign bus.vld     = fire;
    assign bus.last    = fire && (win_cnt == WCW'(N_WIN - 1));
    assign bus.bsy_out = bsy_q;
    assign bus.dout    = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            mac_cnt <= 1'b0;
            pv      <= 1'b0;
            p0      <= '0;
            p1      <= '0;
            acc     <= '0;
            win_cnt <= '0;
            bsy_q   <= 1'b0;
            dout_q  <= '0;
        end else if (tx_done) begin
            state   <= IDLE;
            k       <= '0;
            mac_cnt <= 1'b0;
            pv      <= 1'b0;
            acc     <= '0;
            win_cnt <= '0;
            bsy_q   <= 1'b0;
        end else begin
            // Product stage: one sample per channel per CAP cycle, summed a cycle later.
            pv <= (state == CAP);
            if (state == CAP) begin
                p0 <= bus.din_0 * w0;
                p1 <= bus.din_1 * w1;
            end
            if (pv)
                acc <= acc + AW'(p0) + AW'(p1);

            case (state)
                IDLE: begin
                    if (bus.rdy) begin
                        state <= CAP;
                        k     <= '0;
                        acc   <= BIAS_INIT;
                        bsy_q <= 1'b1;
                    end
                end
                CAP: begin
                    if (k == 4'(KW - 1)) begin
                        state   <= MAC;
                        mac_cnt <= 1'b0;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                MAC: begin
                    // Second MAC cycle: the last product has been folded into acc.
                    if (mac_cnt) begin
                        state  <= OUT;
                        dout_q <= sat_relu(acc, FRAC);
                    end else begin
                        mac_cnt <= 1'b1;
                    end
                end
                OUT, WAIT: begin
                    if (!bus.bsy_in) begin
                        state   <= IDLE;
                        bsy_q   <= 1'b0;
                        win_cnt <= (win_cnt == WCW'(N_WIN - 1)) ? '0 : win_cnt + 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
